// File: rtl/maneuver_seq.sv
// rtl/maneuver_seq.sv - H-bridge maneuver sequencer with dead time, timed drive and overcurrent lockout
module maneuver_seq #(
    parameter int unsigned DEAD_CYCLES = 1000,
    parameter int unsigned RUN_CYCLES  = 100000000,
    parameter int unsigned TURN_CYCLES = 50000000,
    parameter int unsigned COOL_CYCLES = 25000000,
    parameter logic [20:0] DUTY_DRIVE  = 21'd833333,
    parameter logic [20:0] DUTY_TURN   = 21'd416666
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  cmd,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        oc,
    output logic        IN1,
    output logic        IN2,
    output logic        IN3,
    output logic        IN4,
    output logic [20:0] duty,
    output logic        done,
    output logic        fault,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEAD,
        S_RUN,
        S_FAULT
    } state_t;

    localparam logic [2:0] CMD_STOP   = 3'd0;
    localparam logic [2:0] CMD_FWD    = 3'd1;
    localparam logic [2:0] CMD_REV    = 3'd2;
    localparam logic [2:0] CMD_TURN_R = 3'd3;
    localparam logic [2:0] CMD_TURN_L = 3'd4;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  cmd_q, cmd_d;
    logic [3:0]  in_q, in_d;
    logic [20:0] duty_q, duty_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        fault_q, fault_d;

    logic        accept;
    logic        is_drive;
    logic [31:0] run_limit;

    assign accept    = cmd_valid && (state_q == S_IDLE);
    assign is_drive  = (cmd_q == CMD_FWD) || (cmd_q == CMD_REV);
    assign run_limit = is_drive ? RUN_CYCLES : TURN_CYCLES;

    // Next-state, duration counter and registered-output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        cmd_d   = cmd_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        in_d    = 4'b0000;
        duty_d  = 21'd0;

        case (state_q)
            S_IDLE: begin
                cnt_d = 32'd0;
                // Overcurrent wins over a command presented on the same edge
                if (oc) begin
                    state_d = S_FAULT;
                end else if (accept) begin
                    case (cmd)
                        CMD_STOP: done_d = 1'b1;
                        CMD_FWD, CMD_REV, CMD_TURN_R, CMD_TURN_L: begin
                            cmd_d   = cmd;
                            state_d = S_DEAD;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_DEAD: begin
                if (oc) begin
                    state_d = S_FAULT;
                    cnt_d   = 32'd0;
                end else if (cnt_q == DEAD_CYCLES - 1) begin
                    state_d = S_RUN;
                    cnt_d   = 32'd0;
                end
            end
            S_RUN: begin
                if (oc) begin
                    state_d = S_FAULT;
                    cnt_d   = 32'd0;
                end else if (cnt_q == run_limit - 32'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 32'd0;
                    done_d  = 1'b1;
                end
            end
            S_FAULT: begin
                // Cooldown only counts clocks with oc low; any oc restarts it
                if (oc) begin
                    cnt_d = 32'd0;
                end else if (cnt_q == COOL_CYCLES - 1) begin
                    state_d = S_IDLE;
                    cnt_d   = 32'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 32'd0;
            end
        endcase

        // Bridge outputs follow the next state so they switch with the state register
        if (state_d == S_RUN) begin
            case (cmd_d)
                CMD_FWD:    begin in_d = 4'b1010; duty_d = DUTY_DRIVE; end
                CMD_REV:    begin in_d = 4'b0101; duty_d = DUTY_DRIVE; end
                CMD_TURN_R: begin in_d = 4'b0110; duty_d = DUTY_TURN;  end
                CMD_TURN_L: begin in_d = 4'b1001; duty_d = DUTY_TURN;  end
                default:    begin in_d = 4'b0000; duty_d = 21'd0;      end
            endcase
        end

        fault_d = (state_d == S_FAULT);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 32'd0;
            cmd_q   <= CMD_STOP;
            in_q    <= 4'b0000;
            duty_q  <= 21'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            in_q    <= in_d;
            duty_q  <= duty_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fault_q <= fault_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign IN1       = in_q[3];
    assign IN2       = in_q[2];
    assign IN3       = in_q[1];
    assign IN4       = in_q[0];
    assign duty      = duty_q;
    assign done      = done_q;
    assign err       = err_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_maneuver_seq.sv
// tb/tb_maneuver_seq.sv - scoreboard testbench for maneuver_seq
module tb_maneuver_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  cmd;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        oc;
    logic        IN1, IN2, IN3, IN4;
    logic [20:0] duty;
    logic        done, fault, err;

    int checks = 0;
    int errors = 0;

    logic [28:0] exp_q[$];

    maneuver_seq #(
        .DEAD_CYCLES(4),
        .RUN_CYCLES (20),
        .TURN_CYCLES(10),
        .COOL_CYCLES(8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cmd      (cmd),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .oc       (oc),
        .IN1      (IN1),
        .IN2      (IN2),
        .IN3      (IN3),
        .IN4      (IN4),
        .duty     (duty),
        .done     (done),
        .fault    (fault),
        .err      (err)
    );

    always #5 clock = ~clock;

    // Output vector layout: {IN1..IN4, duty, done, fault, err, cmd_ready}
    function automatic logic [28:0] mk(input logic [3:0] in4, input logic [20:0] d,
                                       input logic dn, input logic f, input logic e, input logic r);
        return {in4, d, dn, f, e, r};
    endfunction

    function automatic logic [28:0] observe();
        return {IN1, IN2, IN3, IN4, duty, done, fault, err, cmd_ready};
    endfunction

    localparam logic [20:0] D_DRIVE = 21'd833333;
    localparam logic [20:0] D_TURN  = 21'd416666;

    logic [28:0] v_idle, v_dead, v_done, v_err, v_fault, v_fwd, v_rev, v_tr, v_tl;

    task automatic push(input logic [28:0] v, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(v);
    endtask

    task automatic accept(input logic [2:0] c);
        cmd       = c;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [28:0] obs, exp;
        int idx;
        reset = 1'b1; cmd = 3'd0; cmd_valid = 1'b0; oc = 1'b0;
        repeat (2) @(posedge clock);
        push(v_idle, 4);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            obs = observe(); exp = exp_q.pop_front(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset cycle %0d: got %h expected %h", idx, obs, exp);
            end
            if (idx == 1) reset = 1'b0;
            idx++;
        end
    endtask

    task automatic test_turn(input logic [2:0] c, input logic [28:0] vrun, input string name);
        logic [28:0] obs, exp;
        int idx;
        accept(c);
        push(v_dead, 4); push(vrun, 10); push(v_done, 1); push(v_idle, 1);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            obs = observe(); exp = exp_q.pop_front(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s cycle t+%0d: got %h expected %h", name, idx + 1, obs, exp);
            end
            idx++;
        end
    endtask

    task automatic test_back_to_back();
        logic [28:0] obs, exp;
        int idx;
        accept(3'd1);
        push(v_dead, 4); push(v_fwd, 20); push(v_done, 1);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            obs = observe(); exp = exp_q.pop_front(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL fwd cycle t+%0d: got %h expected %h", idx + 1, obs, exp);
            end
            idx++;
        end
        accept(3'd2);
        push(v_dead, 4); push(v_rev, 20); push(v_done, 1); push(v_idle, 1);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            obs = observe(); exp = exp_q.pop_front(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rev_b2b cycle t+%0d: got %h expected %h", idx + 1, obs, exp);
            end
            idx++;
        end
    endtask

    task automatic test_oc_run();
        logic [28:0] obs, exp;
        int idx;
        accept(3'd1);
        push(v_dead, 4); push(v_fwd, 5); push(v_fault, 10); push(v_idle, 2);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            obs = observe(); exp = exp_q.pop_front(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL oc_run cycle %0d: got %h expected %h", idx, obs, exp);
            end
            if (idx == 8)  oc = 1'b1;
            if (idx == 11) oc = 1'b0;
            idx++;
        end
    endtask

    task automatic test_illegal_stop();
        logic [28:0] obs, exp;
        logic [2:0] codes [3];
        codes[0] = 3'd6; codes[1] = 3'd7; codes[2] = 3'd0;
        for (int n = 0; n < 3; n++) begin
            accept(codes[n]);
            push((codes[n] == 3'd0) ? v_done : v_err, 1);
            push(v_idle, 1);
            while (exp_q.size() > 0) begin
                @(negedge clock);
                obs = observe(); exp = exp_q.pop_front(); checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL cmd%0d response: got %h expected %h", codes[n], obs, exp);
                end
            end
        end
    endtask

    task automatic test_oc_idle();
        logic [28:0] obs, exp;
        int idx;
        cmd = 3'd1; cmd_valid = 1'b1; oc = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0; oc = 1'b0;
        push(v_fault, 8); push(v_idle, 8);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            obs = observe(); exp = exp_q.pop_front(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL oc_idle cycle %0d: got %h expected %h", idx + 1, obs, exp);
            end
            idx++;
        end
    endtask

    task automatic test_reset_mid();
        logic [28:0] obs, exp;
        int idx;
        accept(3'd1);
        push(v_dead, 4); push(v_fwd, 7); push(v_idle, 6);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            obs = observe(); exp = exp_q.pop_front(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_run cycle %0d: got %h expected %h", idx, obs, exp);
            end
            if (idx == 10) reset = 1'b1;
            if (idx == 11) reset = 1'b0;
            idx++;
        end
        oc = 1'b1;
        push(v_fault, 2); push(v_idle, 4);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            obs = observe(); exp = exp_q.pop_front(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_fault cycle %0d: got %h expected %h", idx, obs, exp);
            end
            if (idx == 1) reset = 1'b1;
            if (idx == 2) begin reset = 1'b0; oc = 1'b0; end
            idx++;
        end
    endtask

    initial begin
        v_idle  = mk(4'b0000, 21'd0,   1'b0, 1'b0, 1'b0, 1'b1);
        v_dead  = mk(4'b0000, 21'd0,   1'b0, 1'b0, 1'b0, 1'b0);
        v_done  = mk(4'b0000, 21'd0,   1'b1, 1'b0, 1'b0, 1'b1);
        v_err   = mk(4'b0000, 21'd0,   1'b0, 1'b0, 1'b1, 1'b1);
        v_fault = mk(4'b0000, 21'd0,   1'b0, 1'b1, 1'b0, 1'b0);
        v_fwd   = mk(4'b1010, D_DRIVE, 1'b0, 1'b0, 1'b0, 1'b0);
        v_rev   = mk(4'b0101, D_DRIVE, 1'b0, 1'b0, 1'b0, 1'b0);
        v_tr    = mk(4'b0110, D_TURN,  1'b0, 1'b0, 1'b0, 1'b0);
        v_tl    = mk(4'b1001, D_TURN,  1'b0, 1'b0, 1'b0, 1'b0);

        test_reset();
        test_turn(3'd3, v_tr, "turn_r");
        test_turn(3'd4, v_tl, "turn_l");
        test_back_to_back();
        test_oc_run();
        test_illegal_stop();
        test_oc_idle();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/maneuver_seq.md
MANEUVER_SEQ -- requirements
Module: maneuver_seq

Interface
REQ-001 The block SHALL have parameter DEAD_CYCLES, default 1000, meaning all-bridge-off clocks inserted before every motion (minimum 1).
REQ-002 The block SHALL have parameter RUN_CYCLES, default 100000000, meaning FWD/REV drive duration in clocks (1 s at 100 MHz, minimum 1).
REQ-003 The block SHALL have parameter TURN_CYCLES, default 50000000, meaning TURN_R/TURN_L drive duration in clocks (0.5 s, minimum 1).
REQ-004 The block SHALL have parameter COOL_CYCLES, default 25000000, meaning fault lockout in clocks counted after oc deasserts (minimum 1).
REQ-005 The block SHALL have parameter DUTY_DRIVE, default 833333, meaning 21-bit PWM width for FWD/REV (50% of the 1666667-clock period).
REQ-006 The block SHALL have parameter DUTY_TURN, default 416666, meaning 21-bit PWM width for turns (25%).
REQ-007 The block SHALL have port clock, input, 1 bit: single system clock (100 MHz); all logic on its rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 The block SHALL have port cmd, input, 3 bits: maneuver code, 0=STOP, 1=FWD, 2=REV, 3=TURN_R, 4=TURN_L, 5-7 illegal.
REQ-010 The block SHALL have port cmd_valid, input, 1 bit: cmd is presented.
REQ-011 The block SHALL have port cmd_ready, output, 1 bit: block can accept cmd.
REQ-012 The block SHALL have port oc, input, 1 bit: overcurrent flag from the bridge, already synchronous to clock.
REQ-013 The block SHALL have ports IN1, IN2, IN3, IN4, output, 1 bit each: bridge direction (right fwd, right back, left fwd, left back).
REQ-014 The block SHALL have port duty, output, 21 bits: PWM width for the downstream PWM stage; 0 means motors off.
REQ-015 The block SHALL have port done, output, 1 bit: one-clock pulse when a maneuver completes normally.
REQ-016 The block SHALL have port fault, output, 1 bit: high while in FAULT.
REQ-017 The block SHALL have port err, output, 1 bit: one-clock pulse when an illegal cmd is accepted.

Function
REQ-018 The block SHALL implement states IDLE, DEAD, RUN and FAULT.
REQ-019 In IDLE, DEAD and FAULT the block SHALL drive IN1-IN4=0000 and duty=0.
REQ-020 The block SHALL drive cmd_ready=1 only in IDLE, and a command SHALL be accepted on the edge where cmd_valid && cmd_ready.
REQ-021 An accepted FWD, REV, TURN_R or TURN_L SHALL latch the code and move the state to DEAD on the next clock.
REQ-022 DEAD SHALL last exactly DEAD_CYCLES clocks, then the state SHALL move to RUN.
REQ-023 RUN SHALL last exactly RUN_CYCLES clocks (FWD/REV) or TURN_CYCLES clocks (turns), then the state SHALL return to IDLE with done=1 for that first IDLE clock only.
REQ-024 In RUN, IN1-IN4 SHALL be FWD=1010, REV=0101, TURN_R=0110, TURN_L=1001, and duty SHALL be DUTY_DRIVE (FWD/REV) or DUTY_TURN (turns).
REQ-025 An accepted STOP SHALL leave the state in IDLE and pulse done for one clock on the following clock.
REQ-026 An accepted illegal code SHALL leave the state in IDLE and pulse err for one clock on the following clock, with no done pulse.
REQ-027 oc=1 sampled in DEAD or RUN SHALL move the state to FAULT on the next clock; the maneuver is abandoned and no done pulse is issued.
REQ-028 oc=1 in IDLE SHALL also move the state to FAULT, and oc has priority over a simultaneous accepted command (the command is dropped).
REQ-029 In FAULT, fault=1 and the cooldown counter SHALL reload while oc=1; after oc falls, FAULT SHALL exit to IDLE once COOL_CYCLES consecutive clocks with oc=0 have elapsed.
REQ-030 Duration counters SHALL be 32-bit unsigned, SHALL clear on every state entry, and SHALL never wrap in normal operation.
REQ-031 Outputs SHALL be registered, so IN1-IN4 and duty change on the same clock as the state register.

Reset
REQ-032 reset=1 SHALL force the following on the next edge, regardless of state: IDLE, IN1-IN4=0000, duty=0, cmd_ready=1 on the first clock after reset release, done=0, fault=0, err=0, counters=0, latched cmd=STOP.
REQ-033 Reset asserted mid-RUN or mid-FAULT SHALL abandon the operation with no done or err pulse.
REQ-034 reset SHALL have priority over oc and cmd_valid.

Verification (DEAD=4, RUN=20, TURN=10, COOL=8)
REQ-035 TURN_R accepted at clock t -> IN=0000, duty=0 for t+1..t+4; then IN=0110, duty=416666 for t+5..t+14; then done=1 at t+15 only, cmd_ready=1.
REQ-036 FWD accepted -> 4 dead clocks, then IN=1010, duty=833333 for 20 clocks, then one done pulse; back-to-back REV gets its own 4 dead clocks before IN=0101.
REQ-037 oc pulsed for 3 clocks at RUN clock 5 -> IN=0000, duty=0 and fault=1 on the next clock; IDLE 8 clocks after oc falls; no done pulse.
REQ-038 cmd=6 accepted -> err=1 for one clock, no done, IN stays 0000; STOP accepted -> done=1 on the next clock only.
REQ-039 cmd_valid and oc both high in IDLE -> FAULT entered, command dropped, no motion after the cooldown.
REQ-040 reset at RUN clock 7 -> all outputs at reset values on the next clock and no done pulse; cmd_ready=1 the clock after reset release.
